// File: rtl/fg_timer_pkg.sv
// Shared types for the multi-channel function-generator timer.
//   fg_mode_e : per-channel counting mode (2 bits)
//   FG_MODE_W : width of one mode field in the packed mode bus
package fg_timer_pkg;

    localparam int unsigned FG_MODE_W = 2;

    typedef enum logic [FG_MODE_W-1:0] {
        FG_MODE_COMPARE = 2'd0,
        FG_MODE_ACCUM   = 2'd1,
        FG_MODE_ONESHOT = 2'd2,
        FG_MODE_UPDOWN  = 2'd3
    } fg_mode_e;

endpackage

// File: rtl/fg_prescaler.sv
// Shared clock-divider for all timer channels.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   prescaler  : divide value, one tick every prescaler+1 cycles
//   tick       : combinational tick, forced low while rst_n is asserted
module fg_prescaler #(
    parameter int unsigned PSC_BITWIDTH = 9
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [PSC_BITWIDTH-1:0] prescaler,
    output logic                    tick
);

    logic [PSC_BITWIDTH-1:0] psc_q;
    logic [PSC_BITWIDTH-1:0] psc_d;
    logic                    tick_raw;

    // >= rather than == so a lowered divide value ticks at once instead of
    // running the counter all the way round.
    assign tick_raw = (psc_q >= prescaler);

    // No overflow: the increment only happens while psc_q < prescaler.
    assign psc_d = tick_raw ? '0 : psc_q + PSC_BITWIDTH'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc_q <= '0;
        end else begin
            psc_q <= psc_d;
        end
    end

    assign tick = tick_raw & rst_n;

endmodule

// File: rtl/fg_timer_mc.sv
// Multi-channel timer: one shared prescaler, NUM_CH independent counters,
// each in COMPARE, ACCUM, ONESHOT or UPDOWN mode.
// Ports:
//   clk_i, rstn_i  : clock, asynchronous active-low reset
//   enable_i       : per-channel run enable
//   mode_i         : per-channel mode, FG_MODE_W bits each
//   prescaler_i    : shared divide value
//   period_i       : per-channel top value (step in ACCUM)
//   compare_i      : per-channel compare threshold
//   preload_i      : per-channel ACCUM start phase
//   update_i       : force shadow reload on all channels
//   counterVal_o   : per-channel counter, channel n at [n*CW +: CW]
//   clk_en_o       : prescaler tick (combinational)
//   wrap_o         : one-cycle period-event pulse
//   cmp_o          : counter < active compare (combinational)
//   done_o         : ONESHOT finished level
// Build option: define FG_TIMER_SHADOW_EN to hold mode/period/compare in
// shadow registers that reload on wrap, update_i, or while disabled.
module fg_timer_mc
    import fg_timer_pkg::*;
#(
    parameter int unsigned COUNTER_BITWIDTH = 10,
    parameter int unsigned PSC_BITWIDTH     = 9,
    parameter int unsigned NUM_CH           = 2
) (
    input  logic                             clk_i,
    input  logic                             rstn_i,
    input  logic [NUM_CH-1:0]                enable_i,
    input  logic [FG_MODE_W*NUM_CH-1:0]      mode_i,
    input  logic [PSC_BITWIDTH-1:0]          prescaler_i,
    input  logic [NUM_CH*COUNTER_BITWIDTH-1:0] period_i,
    input  logic [NUM_CH*COUNTER_BITWIDTH-1:0] compare_i,
    input  logic [NUM_CH*COUNTER_BITWIDTH-1:0] preload_i,
    input  logic                             update_i,
    output logic [NUM_CH*COUNTER_BITWIDTH-1:0] counterVal_o,
    output logic                             clk_en_o,
    output logic [NUM_CH-1:0]                wrap_o,
    output logic [NUM_CH-1:0]                cmp_o,
    output logic [NUM_CH-1:0]                done_o
);

    localparam int unsigned CW = COUNTER_BITWIDTH;

    logic tick;

    fg_prescaler #(
        .PSC_BITWIDTH(PSC_BITWIDTH)
    ) u_prescaler (
        .clk       (clk_i),
        .rst_n     (rstn_i),
        .prescaler (prescaler_i),
        .tick      (tick)
    );

    assign clk_en_o = tick;

`ifndef FG_TIMER_SHADOW_EN
    // Without shadows the live inputs are the active config; update_i has no role.
    logic unused_update;
    assign unused_update = update_i;
`endif

    for (genvar n = 0; n < int'(NUM_CH); n++) begin : g_ch

        logic          en;
        fg_mode_e      mode_in;
        logic [CW-1:0] period_in;
        logic [CW-1:0] compare_in;
        logic [CW-1:0] preload_in;

        fg_mode_e      mode_act;
        logic [CW-1:0] period_act;
        logic [CW-1:0] compare_act;

        logic [CW-1:0] cnt_q, cnt_d;
        logic          dir_q, dir_d;   // 1 = counting up
        logic          wrap_q, wrap_d;
        logic          done_q, done_d;
        logic [CW:0]   acc_sum;

        assign en         = enable_i[n];
        assign mode_in    = fg_mode_e'(mode_i[n*FG_MODE_W +: FG_MODE_W]);
        assign period_in  = period_i[n*CW +: CW];
        assign compare_in = compare_i[n*CW +: CW];
        assign preload_in = preload_i[n*CW +: CW];

`ifdef FG_TIMER_SHADOW_EN
        fg_mode_e      mode_sh;
        logic [CW-1:0] period_sh;
        logic [CW-1:0] compare_sh;
        logic          shadow_load;

        // wrap_d is only ever set on a tick, so this is the wrap edge itself.
        assign shadow_load = !en | update_i | wrap_d;

        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                mode_sh    <= FG_MODE_COMPARE;
                period_sh  <= '0;
                compare_sh <= '0;
            end else if (shadow_load) begin
                mode_sh    <= mode_in;
                period_sh  <= period_in;
                compare_sh <= compare_in;
            end
        end

        assign mode_act    = mode_sh;
        assign period_act  = period_sh;
        assign compare_act = compare_sh;
`else
        assign mode_act    = mode_in;
        assign period_act  = period_in;
        assign compare_act = compare_in;
`endif

        assign acc_sum = {1'b0, cnt_q} + {1'b0, period_act};

        // Next-state for one channel; counters move only on a prescaler tick.
        always_comb begin
            cnt_d  = cnt_q;
            dir_d  = dir_q;
            wrap_d = 1'b0;
            done_d = done_q;

            if (!en) begin
                cnt_d  = (mode_in == FG_MODE_ACCUM) ? preload_in : '0;
                dir_d  = 1'b1;
                done_d = 1'b0;
            end else begin
                if (mode_act != FG_MODE_ONESHOT) begin
                    done_d = 1'b0;
                end
                if (mode_act != FG_MODE_UPDOWN) begin
                    dir_d = 1'b1;
                end

                if (tick) begin
                    unique case (mode_act)
                        FG_MODE_COMPARE: begin
                            // >= also catches a period lowered below the count.
                            if (cnt_q >= period_act) begin
                                cnt_d  = '0;
                                wrap_d = 1'b1;
                            end else begin
                                cnt_d = cnt_q + CW'(1);
                            end
                        end

                        FG_MODE_ACCUM: begin
                            cnt_d  = acc_sum[CW-1:0];
                            wrap_d = acc_sum[CW];
                        end

                        FG_MODE_ONESHOT: begin
                            if (!done_q) begin
                                if (cnt_q >= period_act) begin
                                    wrap_d = 1'b1;
                                    done_d = 1'b1;
                                end else begin
                                    cnt_d = cnt_q + CW'(1);
                                    if (cnt_q + CW'(1) == period_act) begin
                                        wrap_d = 1'b1;
                                        done_d = 1'b1;
                                    end
                                end
                            end
                        end

                        FG_MODE_UPDOWN: begin
                            if (period_act == '0) begin
                                cnt_d  = '0;
                                dir_d  = 1'b1;
                                wrap_d = 1'b1;
                            end else if (dir_q) begin
                                if (cnt_q >= period_act) begin
                                    // Turn at the top; a period of 1 lands on 0 at once.
                                    cnt_d = cnt_q - CW'(1);
                                    dir_d = 1'b0;
                                    if (cnt_q == CW'(1)) begin
                                        dir_d  = 1'b1;
                                        wrap_d = 1'b1;
                                    end
                                end else begin
                                    cnt_d = cnt_q + CW'(1);
                                end
                            end else begin
                                if (cnt_q <= CW'(1)) begin
                                    cnt_d  = '0;
                                    dir_d  = 1'b1;
                                    wrap_d = 1'b1;
                                end else begin
                                    cnt_d = cnt_q - CW'(1);
                                end
                            end
                        end
                    endcase
                end
            end
        end

        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                cnt_q  <= '0;
                dir_q  <= 1'b1;
                wrap_q <= 1'b0;
                done_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                dir_q  <= dir_d;
                wrap_q <= wrap_d;
                done_q <= done_d;
            end
        end

        assign counterVal_o[n*CW +: CW] = cnt_q;
        assign wrap_o[n]                = wrap_q;
        assign done_o[n]                = done_q;
        // Gated by reset so cmp_o reads 0 while held in reset even with live config.
        assign cmp_o[n]                 = rstn_i & (cnt_q < compare_act);
    end

endmodule

// File: tb/tb_fg_timer_mc.sv
// Self-checking bench for fg_timer_mc (default parameters, 2 channels).
module tb_fg_timer_mc;
    import fg_timer_pkg::*;

    localparam int unsigned CW  = 10;
    localparam int unsigned PW  = 9;
    localparam int unsigned NCH = 2;

    logic                     clk_i = 1'b0;
    logic                     rstn_i;
    logic [NCH-1:0]           enable_i;
    logic [FG_MODE_W*NCH-1:0] mode_i;
    logic [PW-1:0]            prescaler_i;
    logic [NCH*CW-1:0]        period_i;
    logic [NCH*CW-1:0]        compare_i;
    logic [NCH*CW-1:0]        preload_i;
    logic                     update_i;
    logic [NCH*CW-1:0]        counterVal_o;
    logic                     clk_en_o;
    logic [NCH-1:0]           wrap_o;
    logic [NCH-1:0]           cmp_o;
    logic [NCH-1:0]           done_o;

    fg_timer_mc #(
        .COUNTER_BITWIDTH(CW),
        .PSC_BITWIDTH    (PW),
        .NUM_CH          (NCH)
    ) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .enable_i    (enable_i),
        .mode_i      (mode_i),
        .prescaler_i (prescaler_i),
        .period_i    (period_i),
        .compare_i   (compare_i),
        .preload_i   (preload_i),
        .update_i    (update_i),
        .counterVal_o(counterVal_o),
        .clk_en_o    (clk_en_o),
        .wrap_o      (wrap_o),
        .cmp_o       (cmp_o),
        .done_o      (done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [CW-1:0] cnt;
        logic          wrap;
        logic          cmp;
        logic          done;
        logic          clk_en;
    } obs_t;

    obs_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_ch(input int ch, input fg_mode_e m, input int per, input int cv, input int pre);
        mode_i[ch*FG_MODE_W +: FG_MODE_W] = m;
        period_i[ch*CW +: CW]             = CW'(per);
        compare_i[ch*CW +: CW]            = CW'(cv);
        preload_i[ch*CW +: CW]            = CW'(pre);
    endtask

    function automatic obs_t mk(input int c, input bit w, input bit cm, input bit d, input bit e);
        obs_t o;
        o.cnt = CW'(c); o.wrap = w; o.cmp = cm; o.done = d; o.clk_en = e;
        return o;
    endfunction

    function automatic obs_t observe(input int ch);
        obs_t o;
        o.cnt    = counterVal_o[ch*CW +: CW];
        o.wrap   = wrap_o[ch];
        o.cmp    = cmp_o[ch];
        o.done   = done_o[ch];
        o.clk_en = clk_en_o;
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("cnt=%0d wrap=%b cmp=%b done=%b clk_en=%b", o.cnt, o.wrap, o.cmp, o.done, o.clk_en);
    endfunction

    // Steps until clk_en_o is seen at a sample point (bounded).
    task automatic align_tick(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (clk_en_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rstn_i      = 1'b0;
        enable_i    = '1;
        prescaler_i = '0;
        update_i    = 1'b0;
        set_ch(0, FG_MODE_COMPARE, 7, 5, 0);
        set_ch(1, FG_MODE_COMPARE, 7, 5, 0);
        #23;
        checks++; if (counterVal_o !== '0) begin failures++; $display("FAIL reset_cnt: got %h want 0", counterVal_o); end
        checks++; if (clk_en_o !== 1'b0) begin failures++; $display("FAIL reset_clk_en: got %b want 0", clk_en_o); end
        checks++; if (wrap_o !== '0) begin failures++; $display("FAIL reset_wrap: got %b want 0", wrap_o); end
        checks++; if (cmp_o !== '0) begin failures++; $display("FAIL reset_cmp: got %b want 0", cmp_o); end
        checks++; if (done_o !== '0) begin failures++; $display("FAIL reset_done: got %b want 0", done_o); end
        enable_i = '0;
        #4 rstn_i = 1'b1;
        step();
    endtask

    task automatic test_compare();
        obs_t e, o;
        bit   ok;
        set_ch(0, FG_MODE_COMPARE, 3, 2, 0);
        prescaler_i = PW'(2);
        enable_i    = '0;
        step();
        align_tick(20, ok);
        checks++; if (!ok) begin failures++; $display("FAIL compare_align: got no tick want tick"); end
        step();
        enable_i[0] = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            int t;
            int c;
            t = k / 3;
            c = t % 4;
            sb.push_back(mk(c, (k % 3 == 0) && (c == 0), c < 2, 1'b0, k % 3 == 2));
        end
        for (int i = 0; sb.size() > 0 && i < 64; i++) begin
            step(); e = sb.pop_front(); o = observe(0);
            checks++;
            if (o !== e) begin failures++; $display("FAIL compare_seq step%0d: got %s want %s", i, fmt(o), fmt(e)); end
        end
        enable_i = '0;
    endtask

    task automatic test_accum();
        obs_t e, o;
        prescaler_i = '0;
        set_ch(0, FG_MODE_ACCUM, 30, 0, 1000);
        enable_i = '0;
        step();
        o = observe(0); e = mk(1000, 0, 0, 0, 1);
        checks++; if (o !== e) begin failures++; $display("FAIL accum_preload: got %s want %s", fmt(o), fmt(e)); end
        enable_i[0] = 1'b1;
        sb.push_back(mk(6, 1, 0, 0, 1));
        sb.push_back(mk(36, 0, 0, 0, 1));
        sb.push_back(mk(66, 0, 0, 0, 1));
        for (int i = 0; sb.size() > 0 && i < 64; i++) begin
            step(); e = sb.pop_front(); o = observe(0);
            checks++;
            if (o !== e) begin failures++; $display("FAIL accum_seq step%0d: got %s want %s", i, fmt(o), fmt(e)); end
        end
        enable_i = '0;
    endtask

    task automatic test_oneshot();
        obs_t e, o;
        prescaler_i = '0;
        set_ch(0, FG_MODE_ONESHOT, 4, 3, 0);
        enable_i = '0;
        step();
        enable_i[0] = 1'b1;
        sb.push_back(mk(1, 0, 1, 0, 1));
        sb.push_back(mk(2, 0, 1, 0, 1));
        sb.push_back(mk(3, 0, 0, 0, 1));
        sb.push_back(mk(4, 1, 0, 1, 1));
        sb.push_back(mk(4, 0, 0, 1, 1));
        sb.push_back(mk(4, 0, 0, 1, 1));
        for (int i = 0; sb.size() > 0 && i < 64; i++) begin
            step(); e = sb.pop_front(); o = observe(0);
            checks++;
            if (o !== e) begin failures++; $display("FAIL oneshot_seq step%0d: got %s want %s", i, fmt(o), fmt(e)); end
        end
        enable_i = '0;
        sb.push_back(mk(0, 0, 1, 0, 1));
        for (int i = 0; sb.size() > 0 && i < 64; i++) begin
            step(); e = sb.pop_front(); o = observe(0);
            checks++;
            if (o !== e) begin failures++; $display("FAIL oneshot_disable step%0d: got %s want %s", i, fmt(o), fmt(e)); end
        end
    endtask

    task automatic test_updown();
        obs_t e, o;
        prescaler_i = '0;
        set_ch(0, FG_MODE_COMPARE, 0, 0, 0);
        set_ch(1, FG_MODE_UPDOWN, 2, 1, 0);
        enable_i = '0;
        step();
        o = observe(1); e = mk(0, 0, 1, 0, 1);
        checks++; if (o !== e) begin failures++; $display("FAIL updown_init: got %s want %s", fmt(o), fmt(e)); end
        enable_i[1] = 1'b1;
        for (int r = 0; r < 2; r++) begin
            sb.push_back(mk(1, 0, 0, 0, 1));
            sb.push_back(mk(2, 0, 0, 0, 1));
            sb.push_back(mk(1, 0, 0, 0, 1));
            sb.push_back(mk(0, 1, 1, 0, 1));
        end
        for (int i = 0; sb.size() > 0 && i < 64; i++) begin
            step(); e = sb.pop_front(); o = observe(1);
            checks++;
            if (o !== e) begin failures++; $display("FAIL updown_seq step%0d: got %s want %s", i, fmt(o), fmt(e)); end
        end
        checks++;
        if (counterVal_o[0 +: CW] !== '0) begin failures++; $display("FAIL updown_ch0_idle: got %0d want 0", counterVal_o[0 +: CW]); end
        enable_i = '0;
    endtask

    task automatic test_config_change();
        obs_t e, o;
        prescaler_i = '0;
        set_ch(0, FG_MODE_COMPARE, 7, 0, 0);
        enable_i = '0;
        step();
        enable_i[0] = 1'b1;
        sb.push_back(mk(1, 0, 0, 0, 1));
        sb.push_back(mk(2, 0, 0, 0, 1));
        sb.push_back(mk(3, 0, 0, 0, 1));
        for (int i = 0; sb.size() > 0 && i < 64; i++) begin
            step(); e = sb.pop_front(); o = observe(0);
            checks++;
            if (o !== e) begin failures++; $display("FAIL cfg_pre step%0d: got %s want %s", i, fmt(o), fmt(e)); end
        end
        period_i[0 +: CW] = CW'(2);
`ifdef FG_TIMER_SHADOW_EN
        for (int c = 4; c <= 7; c++) sb.push_back(mk(c, 0, 0, 0, 1));
`endif
        sb.push_back(mk(0, 1, 0, 0, 1));
        sb.push_back(mk(1, 0, 0, 0, 1));
        sb.push_back(mk(2, 0, 0, 0, 1));
        sb.push_back(mk(0, 1, 0, 0, 1));
        for (int i = 0; sb.size() > 0 && i < 64; i++) begin
            step(); e = sb.pop_front(); o = observe(0);
            checks++;
            if (o !== e) begin failures++; $display("FAIL cfg_post step%0d: got %s want %s", i, fmt(o), fmt(e)); end
        end
`ifdef FG_TIMER_SHADOW_EN
        period_i[0 +: CW] = CW'(7);
        enable_i = '0;
        step();
        enable_i[0] = 1'b1;
        step(); step(); step();
        period_i[0 +: CW] = CW'(2);
        update_i = 1'b1;
        step();
        update_i = 1'b0;
        o = observe(0); e = mk(4, 0, 0, 0, 1);
        checks++; if (o !== e) begin failures++; $display("FAIL cfg_update_tick: got %s want %s", fmt(o), fmt(e)); end
        sb.push_back(mk(0, 1, 0, 0, 1));
        sb.push_back(mk(1, 0, 0, 0, 1));
        sb.push_back(mk(2, 0, 0, 0, 1));
        sb.push_back(mk(0, 1, 0, 0, 1));
        for (int i = 0; sb.size() > 0 && i < 64; i++) begin
            step(); e = sb.pop_front(); o = observe(0);
            checks++;
            if (o !== e) begin failures++; $display("FAIL cfg_update_seq step%0d: got %s want %s", i, fmt(o), fmt(e)); end
        end
`endif
        enable_i = '0;
    endtask

    task automatic test_prescaler_lower();
        obs_t e, o;
        bit   ok;
        enable_i = '0;
        set_ch(0, FG_MODE_COMPARE, 0, 0, 0);
        prescaler_i = PW'(100);
        step();
        align_tick(300, ok);
        checks++; if (!ok) begin failures++; $display("FAIL psc_align: got no tick want tick"); end
        step();
        for (int i = 0; i < 50; i++) step();
        checks++; if (clk_en_o !== 1'b0) begin failures++; $display("FAIL psc_mid: got %b want 0", clk_en_o); end
        prescaler_i = PW'(5);
        #1;
        checks++; if (clk_en_o !== 1'b1) begin failures++; $display("FAIL psc_lowered: got %b want 1", clk_en_o); end
        for (int k = 0; k < 5; k++) sb.push_back(mk(0, 0, 0, 0, 0));
        sb.push_back(mk(0, 0, 0, 0, 1));
        for (int i = 0; sb.size() > 0 && i < 64; i++) begin
            step(); e = sb.pop_front(); o = observe(0);
            checks++;
            if (o !== e) begin failures++; $display("FAIL psc_seq step%0d: got %s want %s", i, fmt(o), fmt(e)); end
        end
    endtask

    task automatic test_reset_midcount();
        prescaler_i = '0;
        set_ch(0, FG_MODE_COMPARE, 7, 5, 0);
        set_ch(1, FG_MODE_ONESHOT, 0, 0, 0);
        enable_i = '0;
        step();
        enable_i = '1;
        step(); step(); step();
        checks++; if (counterVal_o[0 +: CW] !== CW'(3)) begin failures++; $display("FAIL mid_cnt: got %0d want 3", counterVal_o[0 +: CW]); end
        checks++; if (done_o !== 2'b10) begin failures++; $display("FAIL mid_done: got %b want 10", done_o); end
        #2 rstn_i = 1'b0;
        #1;
        checks++; if (counterVal_o !== '0) begin failures++; $display("FAIL arst_cnt: got %h want 0", counterVal_o); end
        checks++; if (clk_en_o !== 1'b0) begin failures++; $display("FAIL arst_clk_en: got %b want 0", clk_en_o); end
        checks++; if (cmp_o !== '0) begin failures++; $display("FAIL arst_cmp: got %b want 0", cmp_o); end
        checks++; if (done_o !== '0) begin failures++; $display("FAIL arst_done: got %b want 0", done_o); end
        checks++; if (wrap_o !== '0) begin failures++; $display("FAIL arst_wrap: got %b want 0", wrap_o); end
        enable_i = '0;
        #2 rstn_i = 1'b1;
        step();
    endtask

    initial begin
        enable_i    = '0;
        mode_i      = '0;
        prescaler_i = '0;
        period_i    = '0;
        compare_i   = '0;
        preload_i   = '0;
        update_i    = 1'b0;
        test_reset();
        test_compare();
        test_accum();
        test_oneshot();
        test_updown();
        test_config_change();
        test_prescaler_lower();
        test_reset_midcount();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fg_timer_mc.md
# fg_timer_mc

Multi-channel successor timer for the function generator. It has one shared clock-divider prescaler and NUM_CH independent counter channels. Each channel runs in one of four modes: compare/reload, phase-accumulate, one-shot, or up/down triangle. It also provides per-channel wrap, compare and done outputs, and optional shadow registers for glitch-free reconfiguration. It sits between the register bank and the waveform/DAC datapath and supplies phase/counter values to each output channel.

## Interface
- COUNTER_BITWIDTH, 10, width of each channel counter
- PSC_BITWIDTH, 9, prescaler width
- NUM_CH, 2, number of channels (1..8)
- clk_i  in  1  system clock
- rstn_i  in  1  reset: asynchronous and active-low
- enable_i  in  NUM_CH  per-channel run enable
- mode_i  in  2*NUM_CH  per-channel mode: 0 COMPARE, 1 ACCUM, 2 ONESHOT, 3 UPDOWN
- prescaler_i  in  PSC_BITWIDTH  shared divide value; tick every prescaler_i+1 cycles
- period_i  in  NUM_CH*COUNTER_BITWIDTH  top value (COMPARE/ONESHOT/UPDOWN) or step (ACCUM)
- compare_i  in  NUM_CH*COUNTER_BITWIDTH  compare threshold
- preload_i  in  NUM_CH*COUNTER_BITWIDTH  initial phase for ACCUM
- update_i  in  1  force shadow load on all channels (single-cycle pulse)
- counterVal_o  out  NUM_CH*COUNTER_BITWIDTH  counter registers; channel n at [n*CW +: CW]
- clk_en_o  out  1  prescaler tick
- wrap_o  out  NUM_CH  one-cycle pulse on period event
- cmp_o  out  NUM_CH  1 while counter < active compare
- done_o  out  NUM_CH  ONESHOT finished; level

## Operation
- Prescaler: psc counts 0 up to prescaler_i. Tick = (psc >= prescaler_i), so lowering prescaler_i below the current count produces a tick next cycle rather than a 2^PSC wrap. On tick, psc goes to 0. prescaler_i=0 gives a tick every cycle.
- Channel disabled (enable_i[n]=0): each cycle, the counter is loaded with preload in ACCUM mode and with 0 in all other modes. Direction is set up, done_o=0, wrap_o=0, and the active config is copied from the inputs.
- Enabled channels advance only on a tick:
  - COMPARE: if cnt==period, cnt←0 and wrap; otherwise cnt+1. If period=0, the counter stays 0 and wraps every tick.
  - ACCUM: cnt←cnt+period modulo 2^CW. Wrap fires when the addition carries out. Step 0 holds the count.
  - ONESHOT: cnt+1 until cnt==period. That tick asserts wrap once and sets done. The counter then holds until the channel is disabled.
  - UPDOWN: counts up to period, then down to 0. Wrap fires on the tick where 0 is reached while going down. If period=0, the counter stays 0 and wraps every tick.
- If cnt>period after a config change (COMPARE/ONESHOT), the channel treats it as equal: it wraps or finishes on the next tick. UPDOWN turns down.
- cmp_o[n] = cnt < active compare. compare=0 gives cmp_o always 0.
- A mode change while enabled takes effect through the shadow rules. The counter value is kept.

## Timing
- Reset: psc=0, all counters 0, direction up, counterVal_o=0, clk_en_o=0, wrap_o=0, cmp_o=0, done_o=0, active config 0.
- clk_en_o, cmp_o: combinational from registers, 0-cycle latency.
- Counter, wrap_o, done_o: registered, updated on the clock edge where clk_en_o=1. wrap_o is high for exactly one cycle.
- After an enable rise, the counter holds its initial value until the first tick.
- update_i together with a tick: the tick uses the old config and the new config loads at the same edge.
- Reset asserted mid-count: everything returns to reset values immediately (asynchronous). Release is synchronised by the top level.

## Configuration
- FG_TIMER_SHADOW_EN defined: period/compare/mode are held in per-channel shadow registers. Shadows load on a wrap edge, on update_i, or while the channel is disabled. Input changes mid-period have no effect until one of these.
- Undefined: the active config is the live input (no shadow flops). update_i is ignored.

## Structure
- Package fg_timer_pkg holds the mode enum (FG_MODE_COMPARE/ACCUM/ONESHOT/UPDOWN, 2 bits) and the mode-width constant.
- Sub-module fg_prescaler holds the shared tick generator (psc register, >= compare). There is one instance.
- Channels come from a generate loop inside fg_timer_mc.

## Test plan
- prescaler_i=2, ch0 COMPARE period=3 -> tick every 3rd cycle. Counter sequence 0,1,2,3,0. wrap_o pulses once per 12 cycles.
- ACCUM, CW=10, preload=1000, step=30 -> after the first tick cnt=6 and wrap_o=1. After the second tick cnt=36 and wrap_o=0.
- ONESHOT period=4, prescaler 0 -> count 1..4, done_o=1 from the 4th tick and held. After an enable drop, cnt=0 and done_o=0.
- UPDOWN period=2, compare=1 -> sequence 0,1,2,1,0,1. wrap_o fires on return to 0. cmp_o=1 only at cnt=0.
- Shadow on: COMPARE period=7, cnt=3, period_i changed to 2 -> the count continues to 7 and wraps, then cycles 0..2. Repeat with update_i pulsed at cnt=3 -> the next tick sees cnt>period and wraps.
- prescaler_i lowered from 100 to 5 while psc=50 -> clk_en_o=1 the next cycle. Asserting rstn_i low mid-count -> all outputs 0 without waiting for a clock edge.
